int_control_unit: RTL

- Instruction-sequencing control unit that drives the integer datapath.
- Fetches 16-bit instructions from a unified memory port and decodes them.
- Produces the datapath control word: W_Adr, we, R_Adr, S_Adr, DS, S_Sel, ALU_OP.
- Consumes the datapath results Reg_Out, Alu_Out, N, Z, C. Sits between memory and the datapath as the top-level sequencer.

---
 rtl/int_control_unit_if.sv | 27 ++
 rtl/int_control_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/int_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : int_control_unit_if
// Description : Unified memory port between the control unit (master) and
//               the instruction/data memory (slave). A request is held
//               until the memory answers with mem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface int_control_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/int_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : int_control_unit
// Description : Instruction sequencer for the integer datapath. Fetches
//               16-bit instructions, decodes them and drives the datapath
//               control word; handles loads/stores through the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module int_control_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  ALU_ADD    = 4'h4,
  parameter logic [3:0]  ALU_PASS_S = 4'h1
) (
  input  logic                      clk,
  input  logic                      rst,
  int_control_unit_if.master        bus,
  output logic [2:0]                W_Adr,
  output logic                      we,
  output logic [2:0]                R_Adr,
  output logic [2:0]                S_Adr,
  output logic [15:0]               DS,
  output logic                      S_Sel,
  output logic [3:0]                ALU_OP,
  input  logic [15:0]               Reg_Out,
  input  logic [15:0]               Alu_Out,
  input  logic                      N,
  input  logic                      Z,
  input  logic                      C,
  output logic [15:0]               pc,
  output logic                      halted,
  output logic                      illegal
);

  localparam logic [3:0] OP_RR   = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_ST   = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir, ir_nxt;
  logic [15:0] pc_nxt;
  logic [2:0]  flags, flags_nxt;     // {n,z,c}
  logic        illegal_nxt;
  // Low for the first cycle after reset so no request leaves before the
  // memory side has seen the reset too.
  logic        req_en;

  logic        rd_req;
  logic        wr_req;
  logic [15:0] addr_sel;

  logic [3:0]  op;
  logic [2:0]  rd_f;
  logic [2:0]  rs_f;
  logic [15:0] sext6;
  logic [15:0] sext9;
  logic        br_taken;

  assign op    = ir[15:12];
  assign rd_f  = ir[11:9];
  assign rs_f  = ir[8:6];
  assign sext6 = {{10{ir[5]}}, ir[5:0]};
  assign sext9 = {{7{ir[8]}}, ir[8:0]};

  // An empty mask means "always"; otherwise any selected flag set.
  assign br_taken = (rd_f == 3'b000) || ((rd_f & flags) != 3'b000);

  assign bus.mem_rd    = rd_req;
  assign bus.mem_wr    = wr_req;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = Alu_Out;
  assign halted        = (state == S_HALTED);

  // Architectural state register; reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      flags   <= 3'b000;
      illegal <= 1'b0;
      req_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      flags   <= flags_nxt;
      illegal <= illegal_nxt;
      req_en  <= 1'b1;
    end
  end

  // Sequencer: next state, memory requests and register write enable.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    flags_nxt   = flags;
    illegal_nxt = illegal;
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    addr_sel    = pc;
    we          = 1'b0;
    case (state)
      S_FETCH: begin
        if (req_en) begin
          rd_req = 1'b1;
          if (bus.mem_ready) begin
            ir_nxt    = bus.mem_rdata;
            pc_nxt    = pc + 16'd1;
            state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        case (op)
          OP_RR, OP_LDI, OP_ADDI, OP_BR: state_nxt = S_EXEC;
          OP_LD, OP_ST:                  state_nxt = S_MEM;
          OP_HALT:                       state_nxt = S_HALTED;
          default: begin
            state_nxt   = S_HALTED;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (op == OP_BR) begin
          if (br_taken) pc_nxt = pc + sext9;
        end else begin
          we        = 1'b1;
          flags_nxt = {N, Z, C};
        end
        state_nxt = S_FETCH;
      end
      S_MEM: begin
        addr_sel = Reg_Out;
        if (op == OP_LD) begin
          rd_req = 1'b1;
          we     = bus.mem_ready;
        end else begin
          wr_req = 1'b1;
        end
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_HALTED: begin
        state_nxt = S_HALTED;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Datapath control word decoded straight from the instruction register.
  always_comb begin
    W_Adr  = rd_f;
    R_Adr  = rd_f;
    S_Adr  = rs_f;
    DS     = 16'h0000;
    S_Sel  = 1'b0;
    ALU_OP = ALU_PASS_S;
    case (op)
      OP_RR: begin
        ALU_OP = ir[3:0];
      end
      OP_LDI: begin
        DS    = sext9;
        S_Sel = 1'b1;
      end
      OP_ADDI: begin
        DS     = sext6;
        S_Sel  = 1'b1;
        ALU_OP = ALU_ADD;
      end
      OP_LD: begin
        R_Adr = rs_f;
        DS    = bus.mem_rdata;
        S_Sel = 1'b1;
      end
      OP_ST: begin
        R_Adr = rs_f;
        S_Adr = rd_f;
      end
      default: begin
        ALU_OP = ALU_PASS_S;
      end
    endcase
  end

endmodule
`default_nettype wire
